// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register chain of DEPTH stages with valid bits, flush, freeze, occupancy and hazard detect.
// Latency: DEPTH-1 cycles from capture edge to outputs, plus one per frozen cycle.
// Backpressure: freeze holds every stage and ignores inputs; flush squashes all stages and drops the input.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              WB_EN_in,
    input  logic              Mem_R_EN_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [DATA_W-1:0] Mem_Data_in,
    input  logic [DATA_W-1:0] ALU_res_in,
    input  logic [REG_W-1:0]  src1,
    input  logic [REG_W-1:0]  src2,
    output logic              out_valid,
    output logic              WB_EN,
    output logic              Mem_R_EN,
    output logic [REG_W-1:0]  dest,
    output logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] ALU_res,
    output logic [DATA_W-1:0] wb_value,
    output logic              hazard1,
    output logic              hazard2,
    output logic [2:0]        occupancy
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("mem_wb_pipe: DEPTH must be in 1..4");
    end

    typedef struct packed {
        logic              vld;
        logic              wb_en;
        logic              mem_r_en;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] mem_dat;
        logic [DATA_W-1:0] alu_res;
    } stage_t;

    stage_t     stage_q [DEPTH];
    stage_t     stage_d [DEPTH];
    stage_t     in_stage;
    logic [2:0] occ_q;
    logic [2:0] occ_d;

    // Next-state: flush beats freeze beats advance; bubbles enter fully zeroed
    always_comb begin
        in_stage = '0;
        if (in_valid) begin
            in_stage.vld      = 1'b1;
            in_stage.wb_en    = WB_EN_in;
            in_stage.mem_r_en = Mem_R_EN_in;
            in_stage.dest     = dest_in;
            in_stage.mem_dat  = Mem_Data_in;
            in_stage.alu_res  = ALU_res_in;
        end
        occ_d = occ_q;
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush) begin
            occ_d = 3'd0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end else if (!freeze) begin
            stage_d[0] = in_stage;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            occ_d = occ_q + {2'b00, in_valid} - {2'b00, stage_q[DEPTH-1].vld};
        end
    end

    // Stage registers and occupancy counter with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 3'd0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Forwarding hazard: any valid in-flight stage that will write srcX
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stage_q[k].vld && stage_q[k].wb_en && (stage_q[k].dest == src1)) begin
                hazard1 = 1'b1;
            end
            if (stage_q[k].vld && stage_q[k].wb_en && (stage_q[k].dest == src2)) begin
                hazard2 = 1'b1;
            end
        end
    end

    // Outputs come straight from the last stage; enables gated by its valid
    always_comb begin
        out_valid = stage_q[DEPTH-1].vld;
        WB_EN     = stage_q[DEPTH-1].vld & stage_q[DEPTH-1].wb_en;
        Mem_R_EN  = stage_q[DEPTH-1].vld & stage_q[DEPTH-1].mem_r_en;
        dest      = stage_q[DEPTH-1].dest;
        Mem_Data  = stage_q[DEPTH-1].mem_dat;
        ALU_res   = stage_q[DEPTH-1].alu_res;
        wb_value  = Mem_R_EN ? stage_q[DEPTH-1].mem_dat : stage_q[DEPTH-1].alu_res;
        occupancy = occ_q;
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: DEPTH=2 and DEPTH=4 instances share one stimulus stream.
// Expected values come from directed constants and a queue-based pipeline model.
// Each scenario task checks its own results inline.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        WB_EN_in = 1'b0;
    logic        Mem_R_EN_in = 1'b0;
    logic [3:0]  dest_in = '0;
    logic [31:0] Mem_Data_in = '0;
    logic [31:0] ALU_res_in = '0;
    logic [3:0]  src1 = '0;
    logic [3:0]  src2 = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ov;
        logic        wb;
        logic        mr;
        logic [3:0]  dest;
        logic [31:0] md;
        logic [31:0] alu;
        logic [31:0] wbv;
        logic        h1;
        logic        h2;
        logic [2:0]  occ;
    } obs_t;

    typedef struct packed {
        logic        vld;
        logic        wb;
        logic        mr;
        logic [3:0]  dest;
        logic [31:0] md;
        logic [31:0] alu;
    } bundle_t;

    typedef bundle_t bq_t[$];

    logic        d2_ov, d2_wb, d2_mr, d2_h1, d2_h2;
    logic [3:0]  d2_dest;
    logic [31:0] d2_md, d2_alu, d2_wbv;
    logic [2:0]  d2_occ;
    logic        d4_ov, d4_wb, d4_mr, d4_h1, d4_h2;
    logic [3:0]  d4_dest;
    logic [31:0] d4_md, d4_alu, d4_wbv;
    logic [2:0]  d4_occ;
    obs_t        obs2, obs4;

    assign obs2 = {d2_ov, d2_wb, d2_mr, d2_dest, d2_md, d2_alu, d2_wbv, d2_h1, d2_h2, d2_occ};
    assign obs4 = {d4_ov, d4_wb, d4_mr, d4_dest, d4_md, d4_alu, d4_wbv, d4_h1, d4_h2, d4_occ};

    mem_wb_pipe #(.DATA_W(32), .REG_W(4), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .WB_EN_in(WB_EN_in), .Mem_R_EN_in(Mem_R_EN_in), .dest_in(dest_in),
        .Mem_Data_in(Mem_Data_in), .ALU_res_in(ALU_res_in), .src1(src1), .src2(src2),
        .out_valid(d2_ov), .WB_EN(d2_wb), .Mem_R_EN(d2_mr), .dest(d2_dest),
        .Mem_Data(d2_md), .ALU_res(d2_alu), .wb_value(d2_wbv),
        .hazard1(d2_h1), .hazard2(d2_h2), .occupancy(d2_occ)
    );

    mem_wb_pipe #(.DATA_W(32), .REG_W(4), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .WB_EN_in(WB_EN_in), .Mem_R_EN_in(Mem_R_EN_in), .dest_in(dest_in),
        .Mem_Data_in(Mem_Data_in), .ALU_res_in(ALU_res_in), .src1(src1), .src2(src2),
        .out_valid(d4_ov), .WB_EN(d4_wb), .Mem_R_EN(d4_mr), .dest(d4_dest),
        .Mem_Data(d4_md), .ALU_res(d4_alu), .wb_value(d4_wbv),
        .hazard1(d4_h1), .hazard2(d4_h2), .occupancy(d4_occ)
    );

    // Reference model: one queue entry per stage, index 0 is newest
    bq_t m2;
    bq_t m4;

    function automatic obs_t exp_obs(input bq_t q);
        obs_t    o;
        bundle_t last;
        o    = '0;
        last = q[q.size()-1];
        o.ov   = last.vld;
        o.wb   = last.vld & last.wb;
        o.mr   = last.vld & last.mr;
        o.dest = last.dest;
        o.md   = last.md;
        o.alu  = last.alu;
        o.wbv  = o.mr ? last.md : last.alu;
        foreach (q[i]) begin
            if (q[i].vld) begin
                o.occ = o.occ + 3'd1;
                if (q[i].wb && q[i].dest == src1) o.h1 = 1'b1;
                if (q[i].wb && q[i].dest == src2) o.h2 = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic model_edge();
        bundle_t e;
        if (rst || flush) begin
            foreach (m2[i]) m2[i] = '0;
            foreach (m4[i]) m4[i] = '0;
        end else if (!freeze) begin
            e = '0;
            if (in_valid) begin
                e.vld  = 1'b1;
                e.wb   = WB_EN_in;
                e.mr   = Mem_R_EN_in;
                e.dest = dest_in;
                e.md   = Mem_Data_in;
                e.alu  = ALU_res_in;
            end
            m2.push_front(e);
            void'(m2.pop_back());
            m4.push_front(e);
            void'(m4.pop_back());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic v, input logic wb, input logic mr,
                          input logic [3:0] d, input logic [31:0] md, input logic [31:0] alu);
        in_valid = v; WB_EN_in = wb; Mem_R_EN_in = mr;
        dest_in = d; Mem_Data_in = md; ALU_res_in = alu;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        set_in(0, 0, 0, 4'h0, 32'h0, 32'h0);
        src1 = 4'h0; src2 = 4'h0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 0, 4'h5, 32'h0, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs2 !== '0) begin
                failures++;
                $display("FAIL reset_d2 cyc=%0d got=%h exp=0", i, obs2);
            end
            checks++;
            if (obs4 !== '0) begin
                failures++;
                $display("FAIL reset_d4 cyc=%0d got=%h exp=0", i, obs4);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (d2_occ !== 3'd1 || d2_ov !== 1'b0 || d4_occ !== 3'd1) begin
            failures++;
            $display("FAIL first_capture got d2_occ=%0d d2_ov=%b d4_occ=%0d exp 1 0 1",
                     d2_occ, d2_ov, d4_occ);
        end
    endtask

    task automatic test_latency();
        logic [2:0]  exp_occ [5];
        logic [31:0] exp_wbv [5];
        logic        exp_ov  [5];
        exp_occ = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
        exp_wbv = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        exp_ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_in(1, 1, 0, 4'h1, 32'h0, 32'h11);
                1: set_in(1, 1, 1, 4'h2, 32'h22, 32'h99);
                2: set_in(1, 1, 0, 4'h3, 32'h0, 32'h33);
                default: set_in(0, 0, 0, 4'h0, 32'h0, 32'h0);
            endcase
            step();
            checks++;
            if (d2_occ !== exp_occ[i] || d2_wbv !== exp_wbv[i] || d2_ov !== exp_ov[i]) begin
                failures++;
                $display("FAIL latency cyc=%0d got occ=%0d wbv=%h ov=%b exp occ=%0d wbv=%h ov=%b",
                         i, d2_occ, d2_wbv, d2_ov, exp_occ[i], exp_wbv[i], exp_ov[i]);
            end
            checks++;
            if (obs4 !== exp_obs(m4)) begin
                failures++;
                $display("FAIL latency_d4 cyc=%0d got=%h exp=%h", i, obs4, exp_obs(m4));
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        set_in(1, 1, 0, 4'h4, 32'h0, 32'h44);
        step();
        set_in(1, 1, 0, 4'h5, 32'h0, 32'h55);
        step();
        freeze = 1'b1;
        set_in(1, 1, 0, 4'h9, 32'h0, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (d2_alu !== 32'h44 || d2_dest !== 4'h4 || d2_occ !== 3'd2 || d2_ov !== 1'b1) begin
                failures++;
                $display("FAIL freeze_hold cyc=%0d got alu=%h dest=%h occ=%0d ov=%b exp 44 4 2 1",
                         i, d2_alu, d2_dest, d2_occ, d2_ov);
            end
        end
        freeze = 1'b0;
        set_in(1, 1, 0, 4'h6, 32'h0, 32'h66);
        step();
        checks++;
        if (d2_alu !== 32'h55) begin
            failures++;
            $display("FAIL freeze_resume1 got=%h exp=55", d2_alu);
        end
        set_in(0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (d2_alu !== 32'h66) begin
            failures++;
            $display("FAIL freeze_resume2 got=%h exp=66", d2_alu);
        end
        step();
        checks++;
        if (d2_ov !== 1'b0 || d2_alu !== 32'h0 || d2_occ !== 3'd0) begin
            failures++;
            $display("FAIL freeze_drain got ov=%b alu=%h occ=%0d exp 0 0 0", d2_ov, d2_alu, d2_occ);
        end
    endtask

    task automatic test_flush_freeze();
        do_reset();
        set_in(1, 1, 0, 4'h3, 32'h0, 32'h10);
        step();
        set_in(1, 1, 0, 4'h3, 32'h0, 32'h20);
        step();
        src1 = 4'h3; src2 = 4'h3;
        #1;
        checks++;
        if (d2_h1 !== 1'b1 || d2_occ !== 3'd2) begin
            failures++;
            $display("FAIL preflush got h1=%b occ=%0d exp 1 2", d2_h1, d2_occ);
        end
        flush = 1'b1; freeze = 1'b1;
        set_in(1, 1, 0, 4'h3, 32'h0, 32'h77);
        step();
        checks++;
        if (d2_ov !== 1'b0 || d2_wb !== 1'b0 || d2_occ !== 3'd0 || d2_h1 !== 1'b0 || d2_h2 !== 1'b0) begin
            failures++;
            $display("FAIL flush got ov=%b wb=%b occ=%0d h1=%b h2=%b exp all 0",
                     d2_ov, d2_wb, d2_occ, d2_h1, d2_h2);
        end
        flush = 1'b0; freeze = 1'b0;
        set_in(0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        step();
        checks++;
        if (d2_ov !== 1'b0 || d2_occ !== 3'd0 || d2_alu !== 32'h0) begin
            failures++;
            $display("FAIL flush_drop got ov=%b occ=%0d alu=%h exp 0 0 0", d2_ov, d2_occ, d2_alu);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        set_in(1, 0, 0, 4'h7, 32'h0, 32'h1);
        step();
        set_in(1, 1, 0, 4'h3, 32'h0, 32'h2);
        step();
        src1 = 4'h3; src2 = 4'h7;
        #1;
        checks++;
        if (d2_h1 !== 1'b1) begin
            failures++;
            $display("FAIL hazard_hit got=%b exp=1", d2_h1);
        end
        checks++;
        if (d2_h2 !== 1'b0) begin
            failures++;
            $display("FAIL hazard_wben0 got=%b exp=0", d2_h2);
        end
        set_in(0, 1, 1, 4'h9, 32'h5, 32'h6);
        step();
        src1 = 4'h0; src2 = 4'h3;
        #1;
        checks++;
        if (d2_h1 !== 1'b0 || d2_h2 !== 1'b1) begin
            failures++;
            $display("FAIL hazard_bubble got h1=%b h2=%b exp 0 1", d2_h1, d2_h2);
        end
        checks++;
        if (obs4 !== exp_obs(m4)) begin
            failures++;
            $display("FAIL hazard_d4 got=%h exp=%h", obs4, exp_obs(m4));
        end
    endtask

    task automatic test_bubble();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            set_in(k % 2 == 1, $urandom_range(0, 1), $urandom_range(0, 1),
                   4'($urandom_range(0, 15)), $urandom, $urandom);
            step();
            checks++;
            if (obs4 !== exp_obs(m4)) begin
                failures++;
                $display("FAIL bubble_model k=%0d got=%h exp=%h", k, obs4, exp_obs(m4));
            end
            if (k >= 4) begin
                checks++;
                if (d4_occ !== 3'd2 || d4_ov !== ((k - 3) % 2 == 1)) begin
                    failures++;
                    $display("FAIL bubble_occ k=%0d got occ=%0d ov=%b exp occ=2 ov=%b",
                             k, d4_occ, d4_ov, ((k - 3) % 2 == 1));
                end
                if (!((k - 3) % 2 == 1)) begin
                    checks++;
                    if ({d4_wb, d4_mr, d4_dest, d4_md, d4_alu, d4_wbv} !== '0) begin
                        failures++;
                        $display("FAIL bubble_zero k=%0d got dest=%h md=%h alu=%h wbv=%h exp 0",
                                 k, d4_dest, d4_md, d4_alu, d4_wbv);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int c2;
        int c4;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 99) < 2);
            flush  = ($urandom_range(0, 99) < 5);
            freeze = ($urandom_range(0, 99) < 20);
            set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   4'($urandom_range(0, 3)), $urandom, $urandom);
            src1 = 4'($urandom_range(0, 3));
            src2 = 4'($urandom_range(0, 3));
            step();
            checks++;
            if (obs2 !== exp_obs(m2)) begin
                failures++;
                $display("FAIL rand_d2 cyc=%0d got=%h exp=%h", i, obs2, exp_obs(m2));
            end
            checks++;
            if (obs4 !== exp_obs(m4)) begin
                failures++;
                $display("FAIL rand_d4 cyc=%0d got=%h exp=%h", i, obs4, exp_obs(m4));
            end
            c2 = 0;
            c4 = 0;
            for (int k = 0; k < 2; k++) c2 += int'(u_d2.stage_q[k].vld);
            for (int k = 0; k < 4; k++) c4 += int'(u_d4.stage_q[k].vld);
            checks++;
            if (int'(d2_occ) != c2 || int'(d4_occ) != c4 || d2_occ > 3'd2 || d4_occ > 3'd4) begin
                failures++;
                $display("FAIL rand_occ cyc=%0d got d2=%0d d4=%0d exp popcount d2=%0d d4=%0d",
                         i, d2_occ, d4_occ, c2, c4);
            end
        end
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) m2.push_back('0);
        for (int i = 0; i < 4; i++) m4.push_back('0);
        test_reset();
        test_latency();
        test_freeze();
        test_flush_freeze();
        test_hazard();
        test_bubble();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
